// File: rtl/regfile_mp_pkg.sv
// Shared sizing constants and configuration check for the multi-port decode register file.
package regfile_mp_pkg;

  localparam int RF_REG_SIZE = 32;
  localparam int RF_REG_ADDR = 5;
  localparam int RF_REG_N    = 32;
  localparam int RF_NRD_MAX  = 4;
  localparam int RF_NWR_MAX  = 2;

  function automatic bit rf_cfg_ok(input int nrd, input int nwr, input int n, input int addr);
    return (nrd >= 1) && (nrd <= RF_NRD_MAX) &&
           (nwr >= 1) && (nwr <= RF_NWR_MAX) &&
           (n == (1 << addr));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker: set on issue, cleared on writeback or flush.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int REG_ADDR = RF_REG_ADDR,
  parameter int REG_N    = RF_REG_N,
  parameter int NWR      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_en,
  input  logic [REG_ADDR-1:0]     issue_reg,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR*REG_ADDR-1:0] wreg,
  input  logic                    flush,
  output logic [REG_N-1:0]        pending
);

  logic [REG_N-1:0] pend_q;
  logic [REG_N-1:0] pend_d;

  // Later assignments win: issue supersedes a retiring write, flush beats both.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j]) pend_d[wreg[j*REG_ADDR +: REG_ADDR]] = 1'b0;
    end
    if (issue_en) pend_d[issue_reg] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pending = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero, optional write-to-read bypass
// and a pending-write scoreboard for RAW hazard detection in decode.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int REG_SIZE = RF_REG_SIZE,
  parameter int REG_ADDR = RF_REG_ADDR,
  parameter int REG_N    = RF_REG_N,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD*REG_ADDR-1:0] rreg,
  output logic [NRD*REG_SIZE-1:0] rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR*REG_ADDR-1:0] wreg,
  input  logic [NWR*REG_SIZE-1:0] wdata,
  input  logic                    issue_en,
  input  logic [REG_ADDR-1:0]     issue_reg,
  input  logic                    flush
);

  if (!rf_cfg_ok(NRD, NWR, REG_N, REG_ADDR)) begin : g_cfg_check
    $fatal(1, "regfile_mp: NRD must be 1..4, NWR 1..2 and REG_N == 2**REG_ADDR");
  end

  logic [REG_SIZE-1:0] mem_q [REG_N];
  logic [REG_SIZE-1:0] mem_d [REG_N];
  logic [REG_N-1:0]    pending;
  logic [REG_ADDR-1:0] ra;

  regfile_scoreboard #(
    .REG_ADDR (REG_ADDR),
    .REG_N    (REG_N),
    .NWR      (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_en  (issue_en),
    .issue_reg (issue_reg),
    .wen       (wen),
    .wreg      (wreg),
    .flush     (flush),
    .pending   (pending)
  );

  // Ascending port order lets the highest-index writer win on an address conflict.
  always_comb begin
    mem_d = mem_q;
    for (int j = 0; j < NWR; j++) begin
      if (wen[j] && (wreg[j*REG_ADDR +: REG_ADDR] != '0))
        mem_d[wreg[j*REG_ADDR +: REG_ADDR]] = wdata[j*REG_SIZE +: REG_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_N; r++) mem_q[r] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rreg[k*REG_ADDR +: REG_ADDR];
      if (ra != '0) begin
        rdata[k*REG_SIZE +: REG_SIZE] = mem_q[ra];
        rbusy[k]                      = pending[ra];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wen[j] && (wreg[j*REG_ADDR +: REG_ADDR] == ra)) begin
              rdata[k*REG_SIZE +: REG_SIZE] = wdata[j*REG_SIZE +: REG_SIZE];
              rbusy[k]                      = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: one bypassing and one non-bypassing register file share all stimulus.
module tb_regfile_mp;

  typedef struct packed {
    logic [31:0] d;
    logic        b;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  rreg = '0;
  logic [1:0]  wen = '0;
  logic [9:0]  wreg = '0;
  logic [63:0] wdata = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_reg = '0;
  logic        flush = 1'b0;
  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rbusy_b, rbusy_n;

  obs_t exp_q[$];
  obs_t got_q[$];
  obs_t e, g;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  regfile_mp #(.REG_SIZE(32), .REG_ADDR(5), .REG_N(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .rreg(rreg), .rdata(rdata_b), .rbusy(rbusy_b),
    .wen(wen), .wreg(wreg), .wdata(wdata), .issue_en(issue_en), .issue_reg(issue_reg), .flush(flush)
  );

  regfile_mp #(.REG_SIZE(32), .REG_ADDR(5), .REG_N(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut_nob (
    .clk(clk), .rst_n(rst_n), .rreg(rreg), .rdata(rdata_n), .rbusy(rbusy_n),
    .wen(wen), .wreg(wreg), .wdata(wdata), .issue_en(issue_en), .issue_reg(issue_reg), .flush(flush)
  );

  // Order: bypass dut port0, port1, non-bypass dut port0, port1.
  function automatic void expect4(input logic [31:0] bd0, input logic bb0, input logic [31:0] bd1, input logic bb1,
                                  input logic [31:0] nd0, input logic nb0, input logic [31:0] nd1, input logic nb1);
    exp_q.push_back({bd0, bb0});
    exp_q.push_back({bd1, bb1});
    exp_q.push_back({nd0, nb0});
    exp_q.push_back({nd1, nb1});
  endfunction

  task automatic grab();
    got_q.push_back({rdata_b[31:0], rbusy_b[0]});
    got_q.push_back({rdata_b[63:32], rbusy_b[1]});
    got_q.push_back({rdata_n[31:0], rbusy_n[0]});
    got_q.push_back({rdata_n[63:32], rbusy_n[1]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0;
    issue_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rreg = {5'd6, 5'd5};
    #1 rst_n = 1'b0;
    #2 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    @(negedge clk) rst_n = 1'b1;
    step();
    wen = 2'b01; wreg = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    issue_en = 1'b1; issue_reg = 5'd6;
    #2 expect4(32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0); grab();
    step(); idle();
    #2 expect4(32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1); grab();
    #1 rst_n = 1'b0;
    #1 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    #3 rst_n = 1'b1;
    #1 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    step();
    #2 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset s%0d dut%0d p%0d: got data=%h busy=%b, want data=%h busy=%b", i/4, (i%4)/2, i%2, g.d, g.b, e.d, e.b);
      end
    end
  endtask

  task automatic test_r0();
    step();
    wen = 2'b11; wreg = '0; wdata = {32'hFFFFFFFF, 32'hFFFFFFFF};
    issue_en = 1'b1; issue_reg = 5'd0; rreg = '0;
    #2 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    step(); wen = '0;
    #2 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    step(); idle();
    #2 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL r0 s%0d dut%0d p%0d: got data=%h busy=%b, want data=%h busy=%b", i/4, (i%4)/2, i%2, g.d, g.b, e.d, e.b);
      end
    end
  endtask

  task automatic test_bypass();
    step();
    rreg = {5'd7, 5'd5};
    wen = 2'b01; wreg = {5'd0, 5'd7}; wdata = {32'h0, 32'h0BADF00D};
    #2 expect4(0, 0, 32'h0BADF00D, 0, 0, 0, 0, 0); grab();
    step();
    wdata = {32'h0, 32'h12345678};
    #2 expect4(0, 0, 32'h12345678, 0, 0, 0, 32'h0BADF00D, 0); grab();
    step(); idle();
    #2 expect4(0, 0, 32'h12345678, 0, 0, 0, 32'h12345678, 0); grab();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bypass s%0d dut%0d p%0d: got data=%h busy=%b, want data=%h busy=%b", i/4, (i%4)/2, i%2, g.d, g.b, e.d, e.b);
      end
    end
  endtask

  task automatic test_conflict();
    step();
    rreg = {5'd3, 5'd3};
    wen = 2'b11; wreg = {5'd3, 5'd3}; wdata = {32'h22, 32'h11};
    #2 expect4(32'h22, 0, 32'h22, 0, 0, 0, 0, 0); grab();
    step(); idle();
    #2 expect4(32'h22, 0, 32'h22, 0, 32'h22, 0, 32'h22, 0); grab();
    step();
    wen = 2'b11; wdata = {32'h33, 32'h44};
    #2 expect4(32'h33, 0, 32'h33, 0, 32'h22, 0, 32'h22, 0); grab();
    step(); idle();
    #2 expect4(32'h33, 0, 32'h33, 0, 32'h33, 0, 32'h33, 0); grab();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL conflict s%0d dut%0d p%0d: got data=%h busy=%b, want data=%h busy=%b", i/4, (i%4)/2, i%2, g.d, g.b, e.d, e.b);
      end
    end
  endtask

  task automatic test_scoreboard();
    step();
    rreg = {5'd7, 5'd9};
    issue_en = 1'b1; issue_reg = 5'd9;
    #2 expect4(0, 0, 32'h12345678, 0, 0, 0, 32'h12345678, 0); grab();
    step(); idle();
    #2 expect4(0, 1, 32'h12345678, 0, 0, 1, 32'h12345678, 0); grab();
    step();
    #2 expect4(0, 1, 32'h12345678, 0, 0, 1, 32'h12345678, 0); grab();
    step();
    wen = 2'b10; wreg = {5'd9, 5'd0}; wdata = {32'hAB, 32'h0};
    #2 expect4(32'hAB, 0, 32'h12345678, 0, 0, 1, 32'h12345678, 0); grab();
    step(); idle();
    #2 expect4(32'hAB, 0, 32'h12345678, 0, 32'hAB, 0, 32'h12345678, 0); grab();
    step();
    issue_en = 1'b1; issue_reg = 5'd9;
    wen = 2'b01; wreg = {5'd0, 5'd9}; wdata = {32'h0, 32'hCD};
    #2 expect4(32'hCD, 0, 32'h12345678, 0, 32'hAB, 0, 32'h12345678, 0); grab();
    step(); idle();
    #2 expect4(32'hCD, 1, 32'h12345678, 0, 32'hCD, 1, 32'h12345678, 0); grab();
    step();
    wen = 2'b01; wreg = {5'd0, 5'd9}; wdata = {32'h0, 32'hEF};
    #2 expect4(32'hEF, 0, 32'h12345678, 0, 32'hCD, 1, 32'h12345678, 0); grab();
    step(); idle();
    #2 expect4(32'hEF, 0, 32'h12345678, 0, 32'hEF, 0, 32'h12345678, 0); grab();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL scoreboard s%0d dut%0d p%0d: got data=%h busy=%b, want data=%h busy=%b", i/4, (i%4)/2, i%2, g.d, g.b, e.d, e.b);
      end
    end
  endtask

  task automatic test_flush();
    step();
    rreg = {5'd4, 5'd2};
    wen = 2'b11; wreg = {5'd4, 5'd2}; wdata = {32'h66, 32'h55};
    #2 expect4(32'h55, 0, 32'h66, 0, 0, 0, 0, 0); grab();
    step(); idle();
    issue_en = 1'b1; issue_reg = 5'd2;
    step(); issue_reg = 5'd4;
    #2 expect4(32'h55, 1, 32'h66, 0, 32'h55, 1, 32'h66, 0); grab();
    step(); issue_reg = 5'd6;
    step(); issue_reg = 5'd8; flush = 1'b1;
    #2 expect4(32'h55, 1, 32'h66, 1, 32'h55, 1, 32'h66, 1); grab();
    step(); idle();
    #2 expect4(32'h55, 0, 32'h66, 0, 32'h55, 0, 32'h66, 0); grab();
    #1 rreg = {5'd8, 5'd6};
    #1 expect4(0, 0, 0, 0, 0, 0, 0, 0); grab();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL flush s%0d dut%0d p%0d: got data=%h busy=%b, want data=%h busy=%b", i/4, (i%4)/2, i%2, g.d, g.b, e.d, e.b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
